// File: rtl/b2a_pkg.sv
// rtl/b2a_pkg.sv - shared types and parameter derivations for the b2a_xor_ctrl controller
package b2a_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } b2a_state_t;

    // Fresh random words needed by the masked-XOR datapath for n shares.
    function automatic int b2a_randnum(input int n_shares);
        int log_k;
        if (n_shares <= 1) begin
            return 0;
        end
        log_k = $clog2(n_shares + 1) - 1;
        return log_k * (1 << (log_k - 1)) + n_shares - (1 << log_k);
    endfunction

    function automatic int b2a_maskwidth(input int k_width, input int n_shares);
        return k_width * n_shares;
    endfunction

endpackage

// File: rtl/b2a_rand_buf.sv
// rtl/b2a_rand_buf.sv - collects fresh random words into the mask operand register
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clr_i          zeroize words and rewind the word counter
//   wr_en_i        accepted randomness beat; wr_data_i is the word
//   words_o        word i at [i*K_WIDTH +: K_WIDTH]
//   done_o         this beat fills the last word
module b2a_rand_buf #(
    parameter int K_WIDTH = 32,
    parameter int NWORDS  = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      wr_en_i,
    input  logic [K_WIDTH-1:0]        wr_data_i,
    output logic [K_WIDTH*NWORDS-1:0] words_o,
    output logic                      done_o
);

    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [CW-1:0] cnt;

    assign done_o = wr_en_i && (cnt == CW'(NWORDS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            words_o <= '0;
        end else if (clr_i) begin
            cnt     <= '0;
            words_o <= '0;
        end else if (wr_en_i) begin
            for (int i = 0; i < NWORDS; i++) begin
                if (cnt == CW'(i)) begin
                    words_o[i*K_WIDTH +: K_WIDTH] <= wr_data_i;
                end
            end
            // Hold on the last word; the FSM leaves LOAD on that beat.
            if (!done_o) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/b2a_xor_ctrl.sv
// rtl/b2a_xor_ctrl.sv - sequencing controller for a masked Boolean-share XOR datapath
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   s_valid_i/s_ready_o, s_x_i   shared operand in (share i at [i*K_WIDTH +: K_WIDTH])
//   r_valid_i/r_ready_o, r_data_i fresh randomness words in
//   dp_dvld_o, dp_rvld_o         one-cycle issue strobes to the datapath
//   dp_x_o, dp_n_o               held operands to the datapath
//   dp_dvld_i, dp_z_i            datapath result
//   m_valid_o/m_ready_i, m_z_o   result out
//   busy_o                       not idle
//   err_o                        sticky watchdog error (B2A_XOR_CTRL_WDOG_EN builds only)
module b2a_xor_ctrl
    import b2a_pkg::*;
#(
    parameter  int K_WIDTH   = 32,
    parameter  int N_SHARES  = 3,
    parameter  int WDOG_CYC  = 16,
    localparam int MASKWIDTH = b2a_maskwidth(K_WIDTH, N_SHARES),
    localparam int RANDNUM   = b2a_randnum(N_SHARES),
    localparam int NWORDS    = (RANDNUM > 0) ? RANDNUM : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [MASKWIDTH-1:0]      s_x_i,
    input  logic                      r_valid_i,
    output logic                      r_ready_o,
    input  logic [K_WIDTH-1:0]        r_data_i,
    output logic                      dp_dvld_o,
    output logic                      dp_rvld_o,
    output logic [MASKWIDTH-1:0]      dp_x_o,
    output logic [K_WIDTH*NWORDS-1:0] dp_n_o,
    input  logic [K_WIDTH-1:0]        dp_z_i,
    input  logic                      dp_dvld_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [K_WIDTH-1:0]        m_z_o,
    output logic                      busy_o,
    output logic                      err_o
);

    b2a_state_t state;

    logic s_hs;
    logic out_done;
    logic wdog_fire;
    logic go_idle;
    logic buf_clr;
    logic buf_wr;
    logic buf_done;

    always_comb begin
        s_hs     = 1'b0;
        out_done = 1'b0;
        go_idle  = 1'b0;
        buf_clr  = 1'b0;
        s_hs     = s_valid_i && s_ready_o;
        out_done = (state == ST_OUT) && m_ready_i;
        go_idle  = out_done || wdog_fire;
        // Mask words are wiped on every return to IDLE so no residue lingers.
        buf_clr  = s_hs || go_idle;
    end

    assign buf_wr = r_valid_i && r_ready_o;

    b2a_rand_buf #(
        .K_WIDTH (K_WIDTH),
        .NWORDS  (NWORDS)
    ) u_rand_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (buf_clr),
        .wr_en_i   (buf_wr),
        .wr_data_i (r_data_i),
        .words_o   (dp_n_o),
        .done_o    (buf_done)
    );

`ifdef B2A_XOR_CTRL_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYC + 1);

    logic [WDW-1:0] wdog_cnt;

    // Counts completed WAIT cycles; zero on WAIT entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_cnt <= '0;
        end else if (state != ST_WAIT) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign wdog_fire = (state == ST_WAIT) && !dp_dvld_i && (wdog_cnt == WDW'(WDOG_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (wdog_fire) begin
            err_o <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^WDOG_CYC;
    assign wdog_fire  = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            s_ready_o <= 1'b1;
            r_ready_o <= 1'b0;
            dp_dvld_o <= 1'b0;
            dp_rvld_o <= 1'b0;
            dp_x_o    <= '0;
            m_valid_o <= 1'b0;
            m_z_o     <= '0;
            busy_o    <= 1'b0;
        end else begin
            dp_dvld_o <= 1'b0;
            dp_rvld_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_hs) begin
                        dp_x_o    <= s_x_i;
                        s_ready_o <= 1'b0;
                        busy_o    <= 1'b1;
                        if (RANDNUM == 0) begin
                            state     <= ST_ISSUE;
                            dp_dvld_o <= 1'b1;
                            dp_rvld_o <= 1'b1;
                        end else begin
                            state     <= ST_LOAD;
                            r_ready_o <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (buf_done) begin
                        state     <= ST_ISSUE;
                        r_ready_o <= 1'b0;
                        dp_dvld_o <= 1'b1;
                        dp_rvld_o <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dp_dvld_i) begin
                        m_z_o     <= dp_z_i;
                        m_valid_o <= 1'b1;
                        state     <= ST_OUT;
                    end else if (wdog_fire) begin
                        dp_x_o    <= '0;
                        s_ready_o <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (out_done) begin
                        m_valid_o <= 1'b0;
                        dp_x_o    <= '0;
                        s_ready_o <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    dp_x_o    <= '0;
                    r_ready_o <= 1'b0;
                    m_valid_o <= 1'b0;
                    s_ready_o <= 1'b1;
                    busy_o    <= 1'b0;
                end
            endcase
            // go_idle is referenced so the FSM and buffer agree on IDLE entry.
            if (go_idle) begin
                r_ready_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_b2a_xor_ctrl.sv
// tb/tb_b2a_xor_ctrl.sv - self-checking bench for b2a_xor_ctrl
module tb_b2a_xor_ctrl;

    localparam int K  = 32;
    localparam int N  = 3;
    localparam int MW = K * N;
    localparam int RN = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [MW-1:0] s_x_i;
    logic          r_valid_i;
    logic          r_ready_o;
    logic [K-1:0]  r_data_i;
    logic          dp_dvld_o;
    logic          dp_rvld_o;
    logic [MW-1:0] dp_x_o;
    logic [K*RN-1:0] dp_n_o;
    logic [K-1:0]  dp_z_i;
    logic          dp_dvld_i;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [K-1:0]  m_z_o;
    logic          busy_o;
    logic          err_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    int op_cyc;

    // Reference datapath: XOR of the shares, two-cycle latency.
    logic         dp_auto = 1'b1;
    logic         p0_v = 1'b0, p1_v = 1'b0;
    logic [K-1:0] p0_z = '0, p1_z = '0;

    b2a_xor_ctrl dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_x_i     (s_x_i),
        .r_valid_i (r_valid_i),
        .r_ready_o (r_ready_o),
        .r_data_i  (r_data_i),
        .dp_dvld_o (dp_dvld_o),
        .dp_rvld_o (dp_rvld_o),
        .dp_x_o    (dp_x_o),
        .dp_n_o    (dp_n_o),
        .dp_z_i    (dp_z_i),
        .dp_dvld_i (dp_dvld_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_z_o     (m_z_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic logic [K-1:0] ref_xor(input logic [MW-1:0] x);
        logic [K-1:0] z;
        z = '0;
        for (int i = 0; i < N; i++) z = z ^ x[i*K +: K];
        return z;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        dp_dvld_i = p1_v;
        dp_z_i    = p1_z;
        p1_v      = p0_v;
        p1_z      = p0_z;
        p0_v      = dp_auto && dp_dvld_o;
        p0_z      = dp_x_o[31:0] ^ dp_x_o[63:32] ^ dp_x_o[95:64];
    endtask

    // Handshake the operand and feed both random words; returns in the ISSUE cycle.
    task automatic start_load(input logic [MW-1:0] x, input logic [K-1:0] r0,
                              input logic [K-1:0] r1, input int rgap);
        logic [K-1:0] rw [2];
        int n;
        rw[0] = r0;
        rw[1] = r1;
        op_cyc = 0;
        n = 0;
        while (!s_ready_o && n < 20) begin
            tick();
            n++;
        end
        chk("s_ready_idle", s_ready_o, 1);
        s_valid_i = 1'b1;
        s_x_i     = x;
        tick();
        op_cyc++;
        s_valid_i = 1'b0;
        s_x_i     = {$urandom, $urandom, $urandom};
        chk("busy_load", busy_o, 1);
        chk("s_ready_busy", s_ready_o, 0);
        for (int b = 0; b < RN; b++) begin
            for (int g = 0; g < rgap; g++) begin
                r_valid_i = 1'b0;
                chk("r_ready_gap", r_ready_o, 1);
                chk("no_early_issue", dp_dvld_o, 0);
                tick();
                op_cyc++;
            end
            chk("r_ready_beat", r_ready_o, 1);
            chk("no_early_issue", dp_dvld_o, 0);
            r_valid_i = 1'b1;
            r_data_i  = rw[b];
            tick();
            op_cyc++;
        end
        chk("issue_dvld", dp_dvld_o, 1);
        chk("issue_rvld", dp_rvld_o, 1);
        chk("issue_r_ready", r_ready_o, 0);
        chk("issue_x", dp_x_o, x);
        chk("issue_n", dp_n_o, {r1, r0});
    endtask

    task automatic do_op(input logic [MW-1:0] x, input logic [K-1:0] r0, input logic [K-1:0] r1,
                         input int rgap, input int mhold, input logic [K-1:0] exp_z);
        int n;
        start_load(x, r0, r1, rgap);
        // Randomness offered outside LOAD must not be consumed.
        r_valid_i = 1'b1;
        r_data_i  = 32'hBAD0_0000 ^ $urandom;
        tick();
        op_cyc++;
        n = 0;
        while (!m_valid_o && n < 20) begin
            chk("single_dvld", dp_dvld_o, 0);
            chk("wait_x_stable", dp_x_o, x);
            chk("wait_n_stable", dp_n_o, {r1, r0});
            chk("wait_r_ready", r_ready_o, 0);
            tick();
            op_cyc++;
            n++;
        end
        r_valid_i = 1'b0;
        chk("m_valid", m_valid_o, 1);
        chk("m_z", m_z_o, exp_z);
        for (int h = 0; h < mhold; h++) begin
            m_ready_i = 1'b0;
            tick();
            op_cyc++;
            chk("hold_m_valid", m_valid_o, 1);
            chk("hold_m_z", m_z_o, exp_z);
            chk("hold_s_ready", s_ready_o, 0);
        end
        m_ready_i = 1'b1;
        tick();
        op_cyc++;
        m_ready_i = 1'b0;
        chk("idle_m_valid", m_valid_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_s_ready", s_ready_o, 1);
        chk("idle_x_zero", dp_x_o, 0);
        chk("idle_n_zero", dp_n_o, 0);
        if (rgap == 0 && mhold == 0) chk("op_latency", op_cyc, 1 + RN + 1 + 2 + 1);
    endtask

    typedef struct {
        logic [MW-1:0] x;
        logic [K-1:0]  r0;
        logic [K-1:0]  r1;
        int            rgap;
        int            mhold;
        logic [K-1:0]  z;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [MW-1:0] x;
        int n;

        tbl[0] = '{{32'h44444444, 32'h22222222, 32'h11111111}, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0, 32'h77777777};
        tbl[1] = '{{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 32'h00000000, 32'h00000000, 1, 0, 32'hFFFFFFFF};
        tbl[2] = '{{32'h00000000, 32'h12345678, 32'h12345678}, 32'h13579BDF, 32'h2468ACE0, 0, 10, 32'h00000000};
        tbl[3] = '{{32'h00000000, 32'h00000000, 32'hDEADBEEF}, 32'hFFFFFFFF, 32'h00000001, 2, 3, 32'hDEADBEEF};
        tbl[4] = '{{32'h00FF00FF, 32'hF0F0F0F0, 32'h0F0F0F0F}, 32'hCAFEF00D, 32'h0BADC0DE, 0, 1, 32'hFF00FF00};

        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        s_x_i     = '0;
        r_valid_i = 1'b0;
        r_data_i  = '0;
        dp_z_i    = '0;
        dp_dvld_i = 1'b0;
        m_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_s_ready", s_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_r_ready", r_ready_o, 0);
        chk("rst_m_valid", m_valid_o, 0);
        chk("rst_dvld", {dp_dvld_o, dp_rvld_o}, 0);
        chk("rst_x", dp_x_o, 0);
        chk("rst_n", dp_n_o, 0);
        chk("rst_m_z", m_z_o, 0);
        chk("rst_err", err_o, 0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_op(tbl[i].x, tbl[i].r0, tbl[i].r1, tbl[i].rgap, tbl[i].mhold, tbl[i].z);
        end

        for (int k = 0; k < 100; k++) begin
            x = {$urandom, $urandom, $urandom};
            do_op(x, $urandom, $urandom, ($urandom_range(0, 3) == 0) ? 1 : 0, 0, ref_xor(x));
        end

        // Datapath never answers.
        dp_auto = 1'b0;
        x = {32'h0BAD0BAD, 32'h600DF00D, 32'h12121212};
        start_load(x, 32'h11223344, 32'h55667788, 0);
        r_valid_i = 1'b0;
        tick();
`ifdef B2A_XOR_CTRL_WDOG_EN
        n = 0;
        while (!err_o && n < 40) begin
            chk("wdog_no_m_valid", m_valid_o, 0);
            tick();
            n++;
        end
        chk("wdog_cycles", n, 16);
        chk("wdog_err", err_o, 1);
        chk("wdog_idle", busy_o, 0);
        chk("wdog_m_valid", m_valid_o, 0);
        chk("wdog_x_zero", dp_x_o, 0);
        chk("wdog_n_zero", dp_n_o, 0);
        dp_auto = 1'b1;
        do_op(tbl[0].x, tbl[0].r0, tbl[0].r1, 0, 0, tbl[0].z);
        chk("wdog_err_sticky", err_o, 1);
`else
        for (n = 0; n < 40; n++) tick();
        chk("nowdog_err", err_o, 0);
        chk("nowdog_busy", busy_o, 1);
        chk("nowdog_m_valid", m_valid_o, 0);
        p1_v = 1'b1;
        p1_z = ref_xor(x);
        tick();
        dp_auto = 1'b1;
        tick();
        chk("nowdog_late_m_valid", m_valid_o, 1);
        chk("nowdog_late_m_z", m_z_o, ref_xor(x));
        m_ready_i = 1'b1;
        tick();
        m_ready_i = 1'b0;
        chk("nowdog_idle", busy_o, 0);
`endif

        // Reset during WAIT with a datapath result still in flight.
        start_load(tbl[4].x, tbl[4].r0, tbl[4].r1, 0);
        r_valid_i = 1'b0;
        tick();
        chk("pre_rst_busy", busy_o, 1);
        rst_i = 1'b1;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_s_ready", s_ready_o, 1);
        chk("arst_x", dp_x_o, 0);
        chk("arst_n", dp_n_o, 0);
        chk("arst_m_valid", m_valid_o, 0);
        chk("arst_m_z", m_z_o, 0);
        chk("arst_err", err_o, 0);
        tick();
        chk("late_dvld_driven", dp_dvld_i, 1);
        rst_i = 1'b0;
        tick();
        chk("late_dvld_m_valid", m_valid_o, 0);
        chk("late_dvld_busy", busy_o, 0);
        chk("late_dvld_m_z", m_z_o, 0);
        do_op(tbl[0].x, tbl[0].r0, tbl[0].r1, 0, 0, tbl[0].z);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/b2a_xor_ctrl.md
B2A_XOR_CTRL -- requirements
Module: b2a_xor_ctrl

Interface
REQ-001 SHALL have parameter K_WIDTH, default 32, bit width of one share.
REQ-002 SHALL have parameter N_SHARES, default 3, number of Boolean shares.
REQ-003 SHALL have parameter WDOG_CYC, default 16, watchdog limit in cycles.
REQ-004 SHALL derive MASKWIDTH = K_WIDTH*N_SHARES and RANDNUM = 0 if N_SHARES==1, else LOG_K*2^(LOG_K-1)+N_SHARES-2^LOG_K, with LOG_K = clog2(N_SHARES+1)-1; RANDNUM=2 for N_SHARES=3.
REQ-005 SHALL use one clock; reset is asynchronous and active-high; ports clk_i and rst_i.
REQ-006 clk_i  input  1  clock, rising edge.
REQ-007 rst_i  input  1  asynchronous active-high reset.
REQ-008 s_valid_i / s_ready_o  in/out  1/1  shared-operand handshake.
REQ-009 s_x_i  input  MASKWIDTH  Boolean shares, share i at bits [i*K_WIDTH +: K_WIDTH].
REQ-010 r_valid_i / r_ready_o  in/out  1/1  randomness-word handshake.
REQ-011 r_data_i  input  K_WIDTH  one fresh random word.
REQ-012 dp_dvld_o / dp_rvld_o  output  1/1  data-valid and randomness-valid to the masked-XOR datapath.
REQ-013 dp_x_o  output  MASKWIDTH; dp_n_o  output  K_WIDTH*RANDNUM; operands to datapath.
REQ-014 dp_z_i  input  K_WIDTH; dp_dvld_i  input  1; datapath result and its valid.
REQ-015 m_valid_o / m_ready_i  out/in  1/1; m_z_o  output  K_WIDTH; result handshake.
REQ-016 busy_o  output  1  high in any state other than IDLE; err_o  output  1  sticky watchdog error.

Function
REQ-017 FSM states IDLE, LOAD, ISSUE, WAIT, OUT.
REQ-018 IDLE: s_ready_o=1; on s_valid_i&&s_ready_o capture s_x_i into dp_x_o register, clear word counter, go LOAD (go ISSUE if RANDNUM==0).
REQ-019 LOAD: r_ready_o=1; each r_valid_i beat writes r_data_i into dp_n_o word[count], count+1; after beat RANDNUM-1 go ISSUE; r_ready_o=0 in all other states.
REQ-020 ISSUE: dp_dvld_o=dp_rvld_o=1 for exactly one cycle, then WAIT; dp_x_o/dp_n_o stable from ISSUE until leaving WAIT.
REQ-021 WAIT: first cycle with dp_dvld_i=1 captures dp_z_i into m_z_o, go OUT; dp_dvld_i outside WAIT ignored.
REQ-022 OUT: m_valid_o=1, m_z_o held; on m_ready_i go IDLE; m_valid_o never drops before handshake.
REQ-023 On every entry to IDLE, dp_x_o and dp_n_o SHALL be zeroized (no share/mask residue).
REQ-024 Minimum throughput: 1+RANDNUM+1+datapath latency+1 cycles per operation; no overlap of operations.
REQ-025 s_valid_i while busy SHALL be back-pressured (s_ready_o=0); r_valid_i in non-LOAD states not consumed.
REQ-026 Reset mid-operation aborts: next cycle after deassertion in IDLE, all registers zero.

Reset
REQ-027 On rst_i: state IDLE, counter 0, dp_x_o/dp_n_o/m_z_o 0, dp_dvld_o/dp_rvld_o/m_valid_o/busy_o/err_o 0, s_ready_o 1.

Configuration
REQ-028 Macro B2A_XOR_CTRL_WDOG_EN defined: WAIT counts cycles; on reaching WDOG_CYC without dp_dvld_i, set err_o (sticky until rst_i), zeroize operands, go IDLE, no m_valid_o.
REQ-029 Macro undefined: no watchdog counter, err_o tied 0, WAIT lasts indefinitely.

Structure
REQ-030 Shared package b2a_pkg SHALL hold the FSM state enum and the RANDNUM/MASKWIDTH derivation function.
REQ-031 One sub-module b2a_rand_buf (randomness word collector: counter, word register, fill-done flag) is natural; FSM in top level.

Verification
REQ-032 Shares 0x11111111,0x22222222,0x44444444, randoms 0xA5A5A5A5,0x5A5A5A5A, reference datapath latency 2 -> single dp_dvld_o pulse with dp_n_o={0x5A5A5A5A,0xA5A5A5A5}, m_z_o=0x77777777.
REQ-033 r_valid_i toggling every other cycle -> exactly 2 words consumed, ISSUE only after second, no extra r_ready_o.
REQ-034 m_ready_i held low 10 cycles in OUT -> m_valid_o and m_z_o stable, s_ready_o=0 throughout.
REQ-035 100 back-to-back random operations, m_ready_i=1 -> each m_z_o equals XOR of its three shares, after IDLE dp_x_o=dp_n_o=0.
REQ-036 rst_i pulsed during WAIT -> all outputs reset values asynchronously, late dp_dvld_i ignored.
REQ-037 With B2A_XOR_CTRL_WDOG_EN, dp_dvld_i never asserted -> err_o=1 exactly 16 cycles after WAIT entry, state IDLE, m_valid_o stays 0.
